// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared state encoding and arithmetic helpers for divider_seq.
// Revision : 1.0
// ============================================================================
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [63:0] negate(input logic [63:0] value);
        return ~value + 64'd1;
    endfunction

    function automatic logic [63:0] abs_val(input logic [63:0] value, input logic is_neg);
        return is_neg ? negate(value) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_step.sv
`default_nettype none
// ============================================================================
// Module   : divider_step
// Brief    : One combinational restoring-division iteration (critical path).
// Revision : 1.0
// ============================================================================
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_msb;

    // The partial remainder is always below the divisor, so its top bit is
    // zero on entry and the shifted value still fits in WIDTH+1 bits.
    assign unused_msb = rem_in[WIDTH];
    assign shifted    = {rem_in[WIDTH-1:0], dvd_bit};
    assign diff       = {1'b0, shifted} - {2'b00, dsr};
    assign q_bit      = ~diff[WIDTH+1];
    assign rem_out    = q_bit ? diff[WIDTH:0] : shifted;

endmodule
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : divider_seq
// Brief    : Iterative signed/unsigned divider with start/ready/done handshake.
// Revision : 1.0
// ============================================================================
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int                CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, next_state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   part_rem, step_rem;
    logic [WIDTH-1:0] dvd_shift, dsr_mag, quo_shift;
    logic             neg_quo, neg_rem, step_bit;
    logic             accept, dvd_neg, dsr_neg, is_zero, is_ovf;
    logic [WIDTH-1:0] dvd_abs, dsr_abs, quo_fixed, rem_fixed;

    assign accept   = start && (state == IDLE);
    assign dvd_neg  = is_signed && dividend[WIDTH-1];
    assign dsr_neg  = is_signed && divisor[WIDTH-1];
    assign is_zero  = (divisor == '0);
    assign is_ovf   = is_signed && (dividend == MOST_NEG) && (&divisor);
    assign dvd_abs  = WIDTH'(abs_val(64'(dividend), dvd_neg));
    assign dsr_abs  = WIDTH'(abs_val(64'(divisor), dsr_neg));

    assign quo_fixed = neg_quo ? WIDTH'(negate(64'(quo_shift))) : quo_shift;
    assign rem_fixed = neg_rem ? WIDTH'(negate(64'(part_rem[WIDTH-1:0])))
                               : part_rem[WIDTH-1:0];

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (part_rem),
        .dvd_bit (dvd_shift[WIDTH-1]),
        .dsr     (dsr_mag),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (is_zero || is_ovf) ? DONE : CALC;
            CALC: if (count == LAST_STEP) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are registered alongside the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            ready <= (next_state == IDLE);
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            part_rem    <= '0;
            dvd_shift   <= '0;
            dsr_mag     <= '0;
            quo_shift   <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            count     <= '0;
            part_rem  <= '0;
            dvd_shift <= dvd_abs;
            dsr_mag   <= dsr_abs;
            quo_shift <= '0;
            neg_quo   <= dvd_neg ^ dsr_neg;
            neg_rem   <= dvd_neg;
            // Special cases publish their results directly at capture.
            if (is_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
            end else if (is_ovf) begin
                quotient    <= dividend;
                remainder   <= '0;
                div_by_zero <= 1'b0;
                overflow    <= 1'b1;
            end else begin
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
        end else if (state == CALC) begin
            count     <= count + CNT_W'(1);
            part_rem  <= step_rem;
            dvd_shift <= {dvd_shift[WIDTH-2:0], 1'b0};
            quo_shift <= {quo_shift[WIDTH-2:0], step_bit};
        end else if (state == FIX) begin
            quotient  <= quo_fixed;
            remainder <= rem_fixed;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_seq
// Brief    : Self-checking bench for divider_seq at WIDTH 32, 8 and 16.
// Revision : 1.0
// ============================================================================
module tb_divider_seq;

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        done;
        logic        dz;
        logic        ov;
        logic [31:0] q;
        logic [31:0] r;
    } obs_t;

    typedef struct {
        int          idx;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]       start_v, sgn_v;
    logic [2:0][31:0] dvd_v, dsr_v;
    wire  [2:0]       rdy_v, busy_v, done_v, dz_v, ov_v;
    wire  [2:0][31:0] q_v, r_v;

    int errors = 0;
    int checks = 0;
    vec_t dir_vecs [8];

    always #5 clk = ~clk;

    divider_seq #(.WIDTH(32)) u_d32 (
        .clk(clk), .rst(rst), .start(start_v[0]), .is_signed(sgn_v[0]),
        .dividend(dvd_v[0]), .divisor(dsr_v[0]), .ready(rdy_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .quotient(q_v[0]), .remainder(r_v[0]),
        .div_by_zero(dz_v[0]), .overflow(ov_v[0]));

    divider_seq #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .is_signed(sgn_v[1]),
        .dividend(dvd_v[1][7:0]), .divisor(dsr_v[1][7:0]), .ready(rdy_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .quotient(q_v[1][7:0]), .remainder(r_v[1][7:0]),
        .div_by_zero(dz_v[1]), .overflow(ov_v[1]));

    divider_seq #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .is_signed(sgn_v[2]),
        .dividend(dvd_v[2][15:0]), .divisor(dsr_v[2][15:0]), .ready(rdy_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .quotient(q_v[2][15:0]), .remainder(r_v[2][15:0]),
        .div_by_zero(dz_v[2]), .overflow(ov_v[2]));

    assign q_v[1][31:8]  = '0;
    assign r_v[1][31:8]  = '0;
    assign q_v[2][31:16] = '0;
    assign r_v[2][31:16] = '0;

    function automatic int wd(input int idx);
        return (idx == 0) ? 32 : (idx == 1) ? 8 : 16;
    endfunction

    function automatic obs_t sample(input int idx);
        obs_t o;
        o.ready = rdy_v[idx];
        o.busy  = busy_v[idx];
        o.done  = done_v[idx];
        o.dz    = dz_v[idx];
        o.ov    = ov_v[idx];
        o.q     = q_v[idx];
        o.r     = r_v[idx];
        return o;
    endfunction

    // Reference: plain integer division with truncation toward zero.
    task automatic model(input int w, input logic sgn, input logic [31:0] a_in, input logic [31:0] b_in,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov, output int lat);
        longint m, a, b, sa, sb;
        m  = (longint'(1) << w) - 1;
        a  = longint'(a_in) & m;
        b  = longint'(b_in) & m;
        dz = 1'b0;
        ov = 1'b0;
        lat = w + 2;
        if (b == 0) begin
            q = 32'(m); r = 32'(a); dz = 1'b1; lat = 1;
        end else if (sgn) begin
            sa = ((a >> (w - 1)) & 1) != 0 ? a - (longint'(1) << w) : a;
            sb = ((b >> (w - 1)) & 1) != 0 ? b - (longint'(1) << w) : b;
            if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                q = 32'(a); r = 32'd0; ov = 1'b1; lat = 1;
            end else begin
                q = 32'((sa / sb) & m);
                r = 32'((sa % sb) & m);
            end
        end else begin
            q = 32'(a / b);
            r = 32'(a % b);
        end
    endtask

    // Runs one operation; scrambles inputs while busy to prove they are captured.
    task automatic run_op(input int idx, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output obs_t res, output logic cleared, output logic held_ok);
        obs_t o;
        int   w;
        w       = wd(idx);
        lat     = -1;
        res     = '0;
        cleared = 1'b0;
        held_ok = 1'b0;
        @(negedge clk);
        start_v[idx] = 1'b1; sgn_v[idx] = sgn; dvd_v[idx] = a; dsr_v[idx] = b;
        @(posedge clk); #1;
        start_v[idx] = 1'b0; sgn_v[idx] = 1'($urandom);
        dvd_v[idx] = $urandom; dsr_v[idx] = $urandom;
        for (int k = 1; k <= w + 10; k++) begin
            o = sample(idx);
            if (k == 1) cleared = (o.q == 0) && (o.r == 0) && !o.dz && !o.ov;
            if (o.done) begin
                lat = k;
                res = o;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            o = sample(idx);
            held_ok = o.ready && !o.done && (o.q == res.q) && (o.r == res.r)
                      && (o.dz == res.dz) && (o.ov == res.ov);
        end
    endtask

    task automatic test_reset;
        obs_t o, exp;
        exp = '{ready: 1'b1, busy: 1'b0, done: 1'b0, dz: 1'b0, ov: 1'b0, q: 32'd0, r: 32'd0};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = sample(i);
            checks++;
            if (o !== exp) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, o, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        obs_t res;
        int   lat;
        logic cleared, held_ok;
        dir_vecs = '{
            '{0, 1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 34},
            '{0, 1'b1, 32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0, 34},
            '{0, 1'b1, 32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0, 34},
            '{0, 1'b0, 32'h12345678,  32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 1'b0, 1},
            '{0, 1'b1, 32'h12345678,  32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 1'b0, 1},
            '{1, 1'b1, 32'h80,        32'hFF,         32'h80,         32'h00,         1'b0, 1'b1, 1},
            '{1, 1'b0, 32'h80,        32'hFF,         32'h00,         32'h80,         1'b0, 1'b0, 10},
            '{2, 1'b1, 32'h8000,      32'h0001,       32'h8000,       32'h0000,       1'b0, 1'b0, 18}
        };
        foreach (dir_vecs[n]) begin
            run_op(dir_vecs[n].idx, dir_vecs[n].sgn, dir_vecs[n].a, dir_vecs[n].b,
                   lat, res, cleared, held_ok);
            checks++;
            if (lat !== dir_vecs[n].lat) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d expected %0d", n, lat, dir_vecs[n].lat);
            end
            checks++;
            if ({res.q, res.r, res.dz, res.ov} !== {dir_vecs[n].q, dir_vecs[n].r, dir_vecs[n].dz, dir_vecs[n].ov}) begin
                errors++;
                $display("FAIL directed[%0d] result: got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                         n, res.q, res.r, res.dz, res.ov,
                         dir_vecs[n].q, dir_vecs[n].r, dir_vecs[n].dz, dir_vecs[n].ov);
            end
            checks++;
            if (held_ok !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] hold/ready after done: got %b expected 1", n, held_ok);
            end
            if (dir_vecs[n].lat > 1) begin
                checks++;
                if (cleared !== 1'b1) begin
                    errors++;
                    $display("FAIL directed[%0d] clear after start: got %b expected 1", n, cleared);
                end
            end
        end
    endtask

    task automatic test_busy_start;
        obs_t o, res;
        int   ndone, dcyc;
        ndone = 0;
        dcyc  = -1;
        res   = '0;
        @(negedge clk);
        start_v[0] = 1'b1; sgn_v[0] = 1'b0; dvd_v[0] = 32'd1000; dsr_v[0] = 32'd3;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            o = sample(0);
            if (o.done) begin
                ndone++;
                dcyc = k;
                res  = o;
            end
            if (k == 5 || k == 20) begin
                start_v[0] = 1'b1; dvd_v[0] = 32'd55; dsr_v[0] = 32'd5;
            end else begin
                start_v[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_v[0] = 1'b0;
        checks++;
        if (ndone !== 1 || dcyc !== 34) begin
            errors++;
            $display("FAIL busy_start pulses: got %0d done at cycle %0d expected 1 at 34", ndone, dcyc);
        end
        checks++;
        if (res.q !== 32'd333 || res.r !== 32'd1) begin
            errors++;
            $display("FAIL busy_start result: got q=%0d r=%0d expected q=333 r=1", res.q, res.r);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o, exp, res;
        int   nd, lat;
        logic cleared, held_ok;
        exp = '{ready: 1'b1, busy: 1'b0, done: 1'b0, dz: 1'b0, ov: 1'b0, q: 32'd0, r: 32'd0};
        nd  = 0;
        @(negedge clk);
        start_v[0] = 1'b1; sgn_v[0] = 1'b0; dvd_v[0] = 32'hDEADBEEF; dsr_v[0] = 32'h1234;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid busy before reset: got %b expected 1", busy_v[0]);
        end
        rst = 1'b1;
        #1;
        o = sample(0);
        checks++;
        if (o !== exp) begin
            errors++;
            $display("FAIL reset_mid immediate: got %h expected %h", o, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done_v[0]) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL reset_mid spurious done: got %0d pulses expected 0", nd);
        end
        run_op(0, 1'b0, 32'd100, 32'd7, lat, res, cleared, held_ok);
        checks++;
        if (lat !== 34 || res.q !== 32'd14 || res.r !== 32'd2) begin
            errors++;
            $display("FAIL reset_mid next op: got lat=%0d q=%0d r=%0d expected lat=34 q=14 r=2",
                     lat, res.q, res.r);
        end
    endtask

    function automatic logic [31:0] pick_operand(input int w);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFFFFFF;
            2:       v = 32'd1 << (w - 1);
            3:       v = 32'd1;
            4:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    task automatic test_random(input int idx, input int n_ops);
        obs_t        res;
        int          lat, exp_lat;
        logic        cleared, held_ok, sgn, exp_dz, exp_ov;
        logic [31:0] a, b, exp_q, exp_r;
        for (int n = 0; n < n_ops; n++) begin
            sgn = 1'($urandom);
            a   = pick_operand(wd(idx));
            b   = pick_operand(wd(idx));
            model(wd(idx), sgn, a, b, exp_q, exp_r, exp_dz, exp_ov, exp_lat);
            run_op(idx, sgn, a, b, lat, res, cleared, held_ok);
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL random w%0d latency %h/%h s=%b: got %0d expected %0d",
                         wd(idx), a, b, sgn, lat, exp_lat);
            end
            checks++;
            if ({res.q, res.r, res.dz, res.ov} !== {exp_q, exp_r, exp_dz, exp_ov}) begin
                errors++;
                $display("FAIL random w%0d %h/%h s=%b: got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                         wd(idx), a, b, sgn, res.q, res.r, res.dz, res.ov, exp_q, exp_r, exp_dz, exp_ov);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        sgn_v   = '0;
        dvd_v   = '0;
        dsr_v   = '0;
        test_reset();
        test_directed();
        test_busy_start();
        test_reset_mid();
        test_random(1, 1500);
        test_random(2, 400);
        test_random(0, 250);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
